// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipe_stage_reg: upstream valid/ready/payload in, downstream valid/ready/payload out.
// master = the surrounding pipeline (producer + consumer), slave = the stage register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush, bubble-as-NOP and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer with registered in_ready; otherwise a single entry.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  pipe_stage_reg_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q;
  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = valid_q & bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  // Bubbles must reach the next stage as NOPs, whatever the control register still holds.
  assign bus.out_ctrl  = valid_q ? ctrl_q : '0;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rdy_q;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  assign valid_q      = (state_q != EMPTY);
  assign bus.in_ready = ~flush & rdy_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes from a flop looking at the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main_in) begin
        data_q <= bus.in_data;
        ctrl_q <= bus.in_ctrl;
      end else if (load_main_skid) begin
        data_q <= skid_data_q;
        ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= bus.in_data;
        skid_ctrl_q <= bus.in_ctrl;
      end
    end
  end

`else

  assign bus.in_ready = ~flush & (~valid_q | bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      data_q  <= bus.in_data;
      ctrl_q  <= bus.in_ctrl;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

`endif

  // Flush cycles are not counted as stalls; the entry is being discarded, not held up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (valid_q && !bus.out_ready && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
